// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register: captures ALU result and memory/write-back control,
// resolves beqz/bnez/jumps, pulses a one-cycle fetch redirect and squashes the shadow slot.
module ex_mem_reg #(
  parameter int width = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ex_valid,
  input  logic [0:width-1] alu_out,
  input  logic             zero_signal,
  input  logic [0:width-1] store_data,
  input  logic [4:0]       rd,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic             reg_write,
  input  logic             is_branch,
  input  logic             branch_ne,
  input  logic             is_jump,
  input  logic [0:width-1] pc_plus4,
  input  logic [0:width-1] br_offset,
  input  logic             stall,
  input  logic             flush,
  output logic             m_valid,
  output logic [0:width-1] m_addr,
  output logic [0:width-1] m_wdata,
  output logic [4:0]       m_rd,
  output logic             m_read,
  output logic             m_write,
  output logic             m_reg_write,
  output logic             branch_taken,
  output logic [0:width-1] branch_target
);

  typedef enum logic [0:0] {
    RUN    = 1'b0,
    SHADOW = 1'b1
  } state_t;

  state_t           state_r, state_next_s;
  logic             take_s;
  logic [0:width-1] target_s;

  logic             m_valid_r;
  logic [0:width-1] m_addr_r;
  logic [0:width-1] m_wdata_r;
  logic [4:0]       m_rd_r;
  logic             m_read_r;
  logic             m_write_r;
  logic             m_reg_write_r;
  logic             branch_taken_r;
  logic [0:width-1] branch_target_r;

  // Branch resolution and next-state selection
  always_comb begin
    take_s       = ex_valid & (is_jump | (is_branch & (zero_signal ^ branch_ne)));
    target_s     = pc_plus4 + br_offset;
    state_next_s = state_r;
    case (state_r)
      RUN: begin
        if (flush) begin
          state_next_s = RUN;
        end else if (stall) begin
          state_next_s = RUN;
        end else if (take_s) begin
          state_next_s = SHADOW;
        end else begin
          state_next_s = RUN;
        end
      end
      SHADOW: begin
        // The shadow slot is only consumed by a non-stalled edge.
        if (flush) begin
          state_next_s = RUN;
        end else if (stall) begin
          state_next_s = SHADOW;
        end else begin
          state_next_s = RUN;
        end
      end
      default: state_next_s = RUN;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= RUN;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Pipeline register, redirect pulse and latched target
  always_ff @(posedge clk) begin
    if (reset) begin
      m_valid_r       <= 1'b0;
      m_addr_r        <= {width{1'b0}};
      m_wdata_r       <= {width{1'b0}};
      m_rd_r          <= 5'd0;
      m_read_r        <= 1'b0;
      m_write_r       <= 1'b0;
      m_reg_write_r   <= 1'b0;
      branch_taken_r  <= 1'b0;
      branch_target_r <= {width{1'b0}};
    end else if (flush || (!stall && state_r == SHADOW)) begin
      m_valid_r       <= 1'b0;
      m_addr_r        <= {width{1'b0}};
      m_wdata_r       <= {width{1'b0}};
      m_rd_r          <= 5'd0;
      m_read_r        <= 1'b0;
      m_write_r       <= 1'b0;
      m_reg_write_r   <= 1'b0;
      branch_taken_r  <= 1'b0;
    end else if (stall) begin
      // Contents hold; the redirect pulse never repeats across a stall.
      branch_taken_r  <= 1'b0;
    end else begin
      m_valid_r       <= ex_valid;
      m_addr_r        <= alu_out;
      m_wdata_r       <= store_data;
      m_rd_r          <= rd;
      m_read_r        <= ex_valid & mem_read;
      m_write_r       <= ex_valid & mem_write;
      m_reg_write_r   <= ex_valid & reg_write;
      branch_taken_r  <= take_s;
      if (take_s) begin
        branch_target_r <= target_s;
      end
    end
  end

  assign m_valid       = m_valid_r;
  assign m_addr        = m_addr_r;
  assign m_wdata       = m_wdata_r;
  assign m_rd          = m_rd_r;
  assign m_read        = m_read_r;
  assign m_write       = m_write_r;
  assign m_reg_write   = m_reg_write_r;
  assign branch_taken  = branch_taken_r;
  assign branch_target = branch_target_r;

endmodule

// File: tb/tb_ex_mem_reg.sv
// Directed-vector bench for ex_mem_reg: reset, capture, branch resolution,
// shadow squash, stall/flush interaction and target wrap-around.
module tb_ex_mem_reg;

  logic        clk;
  logic        reset;
  logic        ex_valid;
  logic [31:0] alu_out;
  logic        zero_signal;
  logic [31:0] store_data;
  logic [4:0]  rd;
  logic        mem_read, mem_write, reg_write;
  logic        is_branch, branch_ne, is_jump;
  logic [31:0] pc_plus4, br_offset;
  logic        stall, flush;
  logic        m_valid;
  logic [31:0] m_addr, m_wdata;
  logic [4:0]  m_rd;
  logic        m_read, m_write, m_reg_write;
  logic        branch_taken;
  logic [31:0] branch_target;

  int vec_cnt;
  int err_cnt;

  ex_mem_reg #(.width(32)) dut (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .alu_out(alu_out),
    .zero_signal(zero_signal), .store_data(store_data), .rd(rd),
    .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
    .is_branch(is_branch), .branch_ne(branch_ne), .is_jump(is_jump),
    .pc_plus4(pc_plus4), .br_offset(br_offset), .stall(stall), .flush(flush),
    .m_valid(m_valid), .m_addr(m_addr), .m_wdata(m_wdata), .m_rd(m_rd),
    .m_read(m_read), .m_write(m_write), .m_reg_write(m_reg_write),
    .branch_taken(branch_taken), .branch_target(branch_target)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic set_idle();
    ex_valid = 1'b0; alu_out = 32'h0; zero_signal = 1'b0; store_data = 32'h0;
    rd = 5'd0; mem_read = 1'b0; mem_write = 1'b0; reg_write = 1'b0;
    is_branch = 1'b0; branch_ne = 1'b0; is_jump = 1'b0;
    pc_plus4 = 32'h0; br_offset = 32'h0; stall = 1'b0; flush = 1'b0;
  endtask

  // Advance one edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_cnt = 0;
    err_cnt = 0;
    set_idle();
    reset = 1'b1;
    #1;

    // Reset with random inputs
    for (int i = 0; i < 2; i++) begin
      ex_valid = 1'($urandom); alu_out = $urandom; zero_signal = 1'($urandom);
      store_data = $urandom; rd = 5'($urandom); mem_read = 1'($urandom);
      mem_write = 1'($urandom); reg_write = 1'($urandom); is_branch = 1'($urandom);
      branch_ne = 1'($urandom); is_jump = 1'b1; pc_plus4 = $urandom;
      br_offset = $urandom; stall = 1'($urandom); flush = 1'($urandom);
      step();
    end
    check_val("rst_valid", {31'b0, m_valid}, 32'h0);
    check_val("rst_addr", m_addr, 32'h0);
    check_val("rst_wdata", m_wdata, 32'h0);
    check_val("rst_rd", {27'b0, m_rd}, 32'h0);
    check_val("rst_ctrl", {29'b0, m_read, m_write, m_reg_write}, 32'h0);
    check_val("rst_bt", {31'b0, branch_taken}, 32'h0);
    check_val("rst_target", branch_target, 32'h0);

    // First capture after reset
    reset = 1'b0;
    set_idle();
    ex_valid = 1'b1; alu_out = 32'h0000_1234; store_data = 32'h0000_AA55;
    rd = 5'd5; mem_read = 1'b1; reg_write = 1'b1;
    step();
    check_val("cap_valid", {31'b0, m_valid}, 32'h1);
    check_val("cap_addr", m_addr, 32'h0000_1234);
    check_val("cap_wdata", m_wdata, 32'h0000_AA55);
    check_val("cap_rd", {27'b0, m_rd}, 32'd5);
    check_val("cap_ctrl", {29'b0, m_read, m_write, m_reg_write}, 32'h5);
    check_val("cap_bt", {31'b0, branch_taken}, 32'h0);

    // beqz taken
    set_idle();
    ex_valid = 1'b1; is_branch = 1'b1; branch_ne = 1'b0; zero_signal = 1'b1;
    pc_plus4 = 32'h0000_0100; br_offset = 32'hFFFF_FFF0;
    step();
    check_val("beqz_bt", {31'b0, branch_taken}, 32'h1);
    check_val("beqz_target", branch_target, 32'h0000_00F0);
    check_val("beqz_valid", {31'b0, m_valid}, 32'h1);
    set_idle();
    ex_valid = 1'b1; mem_write = 1'b1; alu_out = 32'h0000_2000; store_data = 32'h77;
    step();
    check_val("shadow_valid", {31'b0, m_valid}, 32'h0);
    check_val("shadow_write", {31'b0, m_write}, 32'h0);
    check_val("shadow_addr", m_addr, 32'h0);
    check_val("shadow_bt", {31'b0, branch_taken}, 32'h0);
    alu_out = 32'h0000_2004;
    step();
    check_val("post_shadow_valid", {31'b0, m_valid}, 32'h1);
    check_val("post_shadow_write", {31'b0, m_write}, 32'h1);
    check_val("post_shadow_addr", m_addr, 32'h0000_2004);

    // bnez not taken
    set_idle();
    ex_valid = 1'b1; is_branch = 1'b1; branch_ne = 1'b1; zero_signal = 1'b1;
    pc_plus4 = 32'h0000_0200; br_offset = 32'h10;
    step();
    check_val("bnez_bt", {31'b0, branch_taken}, 32'h0);
    check_val("bnez_valid", {31'b0, m_valid}, 32'h1);
    set_idle();
    ex_valid = 1'b1; mem_read = 1'b1; reg_write = 1'b1; rd = 5'd7; alu_out = 32'h0000_3000;
    step();
    check_val("bnez_next_valid", {31'b0, m_valid}, 32'h1);
    check_val("bnez_next_addr", m_addr, 32'h0000_3000);
    check_val("bnez_next_bt", {31'b0, branch_taken}, 32'h0);

    // Taken jump followed by a 3-cycle stall
    set_idle();
    ex_valid = 1'b1; is_jump = 1'b1; alu_out = 32'h0000_4444;
    pc_plus4 = 32'h0000_0400; br_offset = 32'h20;
    step();
    check_val("jmp_bt", {31'b0, branch_taken}, 32'h1);
    check_val("jmp_target", branch_target, 32'h0000_0420);
    set_idle();
    ex_valid = 1'b1; mem_write = 1'b1; alu_out = 32'h0000_5000; stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_val("stall_bt", {31'b0, branch_taken}, 32'h0);
      check_val("stall_hold_valid", {31'b0, m_valid}, 32'h1);
      check_val("stall_hold_addr", m_addr, 32'h0000_4444);
    end
    stall = 1'b0;
    step();
    check_val("stall_shadow_valid", {31'b0, m_valid}, 32'h0);
    check_val("stall_shadow_write", {31'b0, m_write}, 32'h0);
    alu_out = 32'h0000_5004;
    step();
    check_val("stall_after_valid", {31'b0, m_valid}, 32'h1);
    check_val("stall_after_addr", m_addr, 32'h0000_5004);

    // Flush on the same edge as a taken jump
    set_idle();
    ex_valid = 1'b1; is_jump = 1'b1; flush = 1'b1; alu_out = 32'h0000_0666;
    pc_plus4 = 32'h0000_0600; br_offset = 32'h4;
    step();
    check_val("flush_bt", {31'b0, branch_taken}, 32'h0);
    check_val("flush_valid", {31'b0, m_valid}, 32'h0);
    set_idle();
    ex_valid = 1'b1; mem_read = 1'b1; alu_out = 32'h0000_6000;
    step();
    check_val("flush_next_valid", {31'b0, m_valid}, 32'h1);
    check_val("flush_next_addr", m_addr, 32'h0000_6000);
    check_val("flush_next_bt", {31'b0, branch_taken}, 32'h0);

    // Target wrap-around
    set_idle();
    ex_valid = 1'b1; is_jump = 1'b1;
    pc_plus4 = 32'hFFFF_FFFC; br_offset = 32'h0000_0008;
    step();
    check_val("wrap_bt", {31'b0, branch_taken}, 32'h1);
    check_val("wrap_target", branch_target, 32'h0000_0004);
    set_idle();
    step();
    check_val("wrap_after_bt", {31'b0, branch_taken}, 32'h0);
    check_val("wrap_after_valid", {31'b0, m_valid}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
